soc_system_switch_ctrl: RTL



---
 rtl/soc_system_switch_pkg.sv | 20 ++
 rtl/soc_system_switch_ctrl_if.sv | 21 ++
 rtl/soc_system_switch_debounce.sv | 52 +++++
 rtl/soc_system_switch_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/soc_system_switch_pkg.sv
// Shared constants and types for the slide-switch controller: register map,
// controller state encoding and counter width helper.
package soc_system_switch_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RAW  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sw_state_e;

  // Bits needed for a counter spanning 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/soc_system_switch_ctrl_if.sv
// Avalon-MM lightweight-bridge slave signals plus the interrupt line.
// Handshake: a write is taken in the cycle chipselect && !write_n (no wait
// states); readdata is registered and reflects address one cycle later.
interface soc_system_switch_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );
endinterface

// File: rtl/soc_system_switch_debounce.sv
// One switch bit: counts consecutive sample ticks disagreeing with the
// accepted level and adopts the new level after STABLE_SAMPLES of them.
module soc_system_switch_debounce
  import soc_system_switch_pkg::*;
#(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic load,
  input  logic sync_bit,
  output logic deb_bit,
  output logic changed
);

  localparam int CW = cnt_w(STABLE_SAMPLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (tick) begin
      // load: settle phase after reset, follow the synchronized line directly
      if (load || (sync_bit != deb_q && cnt_q == CNT_LAST)) begin
        deb_d = sync_bit;
        cnt_d = '0;
      end else if (sync_bit == deb_q) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb_bit = deb_q;
  assign changed = deb_d != deb_q;

endmodule

// File: rtl/soc_system_switch_ctrl.sv
// Slide-switch bank controller: synchronize, debounce, capture edges and
// raise a maskable level interrupt; register view on the lightweight bridge.
module soc_system_switch_ctrl
  import soc_system_switch_pkg::*;
#(
  parameter int WIDTH           = 9,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STABLE_SAMPLES  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  soc_system_switch_ctrl_if.slave  bus,
  input  logic [WIDTH-1:0]         in_port,
  output sw_state_e                state_dbg
);

  localparam int PW = cnt_w(DEBOUNCE_CYCLES);
  localparam int IW = cnt_w(STABLE_SAMPLES);
  localparam logic [PW-1:0] PRE_LAST  = PW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(STABLE_SAMPLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [IW-1:0]    init_cnt_q, init_cnt_d;
  sw_state_e        state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d, edge_q, edge_d;
  logic [31:0]      rd_q, rd_d;

  logic             tick, init_mode, wr_en;
  logic [WIDTH-1:0] deb_vec, changed_vec;
  logic             unused_wdata;

  assign tick      = pre_q == PRE_LAST;
  assign init_mode = state_q == INIT;
  assign wr_en     = bus.chipselect && !bus.write_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    soc_system_switch_debounce #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (tick),
      .load     (init_mode),
      .sync_bit (sync2_q[i]),
      .deb_bit  (deb_vec[i]),
      .changed  (changed_vec[i])
    );
  end

  // Settle FSM: levels present at reset are adopted silently, then RUN forever.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT && tick) begin
      if (init_cnt_q == INIT_LAST) begin
        state_d    = RUN;
        init_cnt_d = '0;
      end else begin
        init_cnt_d = init_cnt_q + IW'(1);
      end
    end
  end

  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
    pre_d   = tick ? '0 : pre_q + PW'(1);
    mask_d  = mask_q;
    edge_d  = edge_q;
    if (wr_en && bus.address == ADDR_MASK) mask_d = bus.writedata[WIDTH-1:0];
    if (wr_en && bus.address == ADDR_EDGE) edge_d = edge_q & ~bus.writedata[WIDTH-1:0];
    // Applied after the clear so a same-cycle level change keeps its bit set.
    if (state_q == RUN) edge_d = edge_d | changed_vec;
    rd_d = '0;
    unique case (bus.address)
      ADDR_DATA: rd_d[WIDTH-1:0] = deb_vec;
      ADDR_RAW:  rd_d[WIDTH-1:0] = sync2_q;
      ADDR_MASK: rd_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: rd_d[WIDTH-1:0] = edge_q;
      default:   rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      pre_q      <= '0;
      init_cnt_q <= '0;
      state_q    <= INIT;
      mask_q     <= '0;
      edge_q     <= '0;
      rd_q       <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      pre_q      <= pre_d;
      init_cnt_q <= init_cnt_d;
      state_q    <= state_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      rd_q       <= rd_d;
    end
  end

  assign unused_wdata = ^bus.writedata;
  assign bus.readdata = rd_q;
  assign bus.irq      = |(edge_q & mask_q);
  assign state_dbg    = state_q;

endmodule
